// File: rtl/latch_frame_loader.sv
// Serial-to-parallel writer for a bank of transparent latches: shifts in a frame MSB first,
// then presents it with one cycle of setup, a STROBE_LEN enable pulse and one cycle of hold.
// Optional even-parity check on a trailing bit is enabled by defining LATCH_FRAME_PARITY_EN.
module latch_frame_loader #(
  parameter int WIDTH      = 8,
  parameter int STROBE_LEN = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             din,
  input  logic             din_valid,
  input  logic             abort,
  output logic [WIDTH-1:0] latch_d,
  output logic             latch_en,
  output logic             latch_rst,
  output logic             busy,
  output logic             done,
  output logic             par_err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = (STROBE_LEN > 1) ? $clog2(STROBE_LEN) : 1;
  localparam logic [CW-1:0] LAST_BIT    = CW'(WIDTH - 1);
  localparam logic [SW-1:0] LAST_STROBE = SW'(STROBE_LEN - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT  = 3'd1,
    PARITY = 3'd2,
    SETUP  = 3'd3,
    STROBE = 3'd4,
    HOLD   = 3'd5
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] shreg_r;
  logic [CW-1:0]    bit_cnt_r;
  logic [SW-1:0]    strobe_cnt_r;
  logic [WIDTH-1:0] word_s;

`ifdef LATCH_FRAME_PARITY_EN
  function automatic logic parity_ok(input logic [WIDTH-1:0] word, input logic pbit);
    return ~((^word) ^ pbit);
  endfunction
`endif

  // Shift register contents after accepting the current din bit.
  always_comb begin
    word_s = (shreg_r << 1) | {{(WIDTH-1){1'b0}}, din};
  end

  // Frame sequencer; every output is a flop so the latch bank sees glitch-free controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      shreg_r      <= {WIDTH{1'b0}};
      bit_cnt_r    <= {CW{1'b0}};
      strobe_cnt_r <= {SW{1'b0}};
      latch_d      <= {WIDTH{1'b0}};
      latch_en     <= 1'b0;
      latch_rst    <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      par_err      <= 1'b0;
    end else begin
      done      <= 1'b0;
      par_err   <= 1'b0;
      latch_rst <= 1'b0;
      if (abort) begin
        // Only an interrupted strobe can leave the latches half-written, so only then clear them.
        state_r  <= IDLE;
        busy     <= 1'b0;
        latch_en <= 1'b0;
        if (state_r == STROBE) begin
          latch_rst <= 1'b1;
        end
      end else begin
        case (state_r)
          IDLE: begin
            if (start) begin
              state_r   <= SHIFT;
              busy      <= 1'b1;
              bit_cnt_r <= {CW{1'b0}};
            end
          end
          SHIFT: begin
            if (din_valid) begin
              shreg_r   <= word_s;
              bit_cnt_r <= bit_cnt_r + CW'(1);
              if (bit_cnt_r == LAST_BIT) begin
`ifdef LATCH_FRAME_PARITY_EN
                state_r <= PARITY;
`else
                state_r <= SETUP;
                latch_d <= word_s;
`endif
              end
            end
          end
`ifdef LATCH_FRAME_PARITY_EN
          PARITY: begin
            if (din_valid) begin
              if (parity_ok(shreg_r, din)) begin
                state_r <= SETUP;
                latch_d <= shreg_r;
              end else begin
                state_r <= IDLE;
                busy    <= 1'b0;
                par_err <= 1'b1;
              end
            end
          end
`endif
          SETUP: begin
            state_r      <= STROBE;
            latch_en     <= 1'b1;
            strobe_cnt_r <= {SW{1'b0}};
          end
          STROBE: begin
            if (strobe_cnt_r == LAST_STROBE) begin
              state_r  <= HOLD;
              latch_en <= 1'b0;
              done     <= 1'b1;
            end else begin
              strobe_cnt_r <= strobe_cnt_r + SW'(1);
            end
          end
          HOLD: begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
          default: begin
            state_r  <= IDLE;
            busy     <= 1'b0;
            latch_en <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_latch_frame_loader.sv
// Randomized self-checking bench for latch_frame_loader; expected outputs come from a per-frame
// timeline computed from the position of the last accepted bit.
module tb_latch_frame_loader;

  localparam int W  = 8;
  localparam int SL = 2;
`ifdef LATCH_FRAME_PARITY_EN
  localparam int NBITS = W + 1;
`else
  localparam int NBITS = W;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         din;
  logic         din_valid;
  logic         abort;
  logic [W-1:0] latch_d;
  logic         latch_en;
  logic         latch_rst;
  logic         busy;
  logic         done;
  logic         par_err;

  int           n_checks = 0;
  int           n_fails  = 0;
  logic [W-1:0] prev_d;
  logic         vseq [0:127];

  always #5 clk = ~clk;

  latch_frame_loader #(.WIDTH(W), .STROBE_LEN(SL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .din(din), .din_valid(din_valid),
    .abort(abort), .latch_d(latch_d), .latch_en(latch_en), .latch_rst(latch_rst),
    .busy(busy), .done(done), .par_err(par_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [W-1:0] e_d, input bit e_en,
                           input bit e_rst, input bit e_busy, input bit e_done, input bit e_perr);
    check({tag, " latch_d"},   32'(latch_d),   32'(e_d));
    check({tag, " latch_en"},  32'(latch_en),  32'(e_en));
    check({tag, " latch_rst"}, 32'(latch_rst), 32'(e_rst));
    check({tag, " busy"},      32'(busy),      32'(e_busy));
    check({tag, " done"},      32'(done),      32'(e_done));
    check({tag, " par_err"},   32'(par_err),   32'(e_perr));
  endtask

  // Per-cycle din_valid pattern; index k is the edge Ek after the start edge E0.
  task automatic fill_valid(input int stall_after, input int stall_len, input bit rnd);
    for (int k = 0; k < 128; k++) begin
      if (rnd) vseq[k] = (k > 40) ? 1'b1 : ($urandom_range(3, 0) != 0);
      else     vseq[k] = !(k > stall_after && k <= stall_after + stall_len);
    end
  endtask

  // Edge at which the last frame bit (data plus optional parity) is accepted.
  function automatic int find_last();
    int c = 0;
    for (int k = 1; k < 128; k++) begin
      if (vseq[k]) c++;
      if (c == NBITS) return k;
    end
    return 127;
  endfunction

  task automatic run_frame(input string name, input logic [W-1:0] word, input logic pbit,
                           input int extra_start, input int abort_at);
    logic [NBITS-1:0] bits;
    int  tl, last_k, nb;
    bit  ok, e_en, e_rst, e_busy, e_done, e_perr;
    logic [W-1:0] e_d;
`ifdef LATCH_FRAME_PARITY_EN
    bits = {word, pbit};
    ok   = (((^word) ^ pbit) == 1'b0);
`else
    bits = word;
    ok   = 1'b1;
`endif
    tl     = find_last();
    last_k = ok ? tl + SL + 2 : tl + 1;
    if (abort_at > 0 && abort_at < last_k) last_k = abort_at + 1;
    @(negedge clk);
    start = 1'b1; abort = 1'b0;
    din_valid = 1'($urandom); din = 1'($urandom);
    @(posedge clk); #1;
    check_all({name, " E0"}, prev_d, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    nb = 0;
    for (int k = 1; k <= last_k; k++) begin
      @(negedge clk);
      start     = (k == extra_start);
      abort     = (k == abort_at);
      din_valid = vseq[k];
      din       = (vseq[k] && nb < NBITS) ? bits[NBITS-1-nb] : 1'($urandom);
      if (vseq[k]) nb++;
      @(posedge clk); #1;
      if (abort_at > 0 && k >= abort_at) begin
        e_d    = (ok && abort_at > tl) ? word : prev_d;
        e_en   = 1'b0;
        e_rst  = (k == abort_at) && (abort_at >= tl + 2) && (abort_at <= tl + SL + 1);
        e_busy = 1'b0; e_done = 1'b0; e_perr = 1'b0;
      end else begin
        e_d    = (ok && k >= tl) ? word : prev_d;
        e_en   = ok && (k >= tl + 1) && (k <= tl + SL);
        e_rst  = 1'b0;
        e_busy = ok ? (k <= tl + SL + 1) : (k < tl);
        e_done = ok && (k == tl + SL + 1);
        e_perr = !ok && (k == tl);
      end
      check_all($sformatf("%s E%0d", name, k), e_d, e_en, e_rst, e_busy, e_done, e_perr);
    end
    if (ok && (abort_at == 0 || abort_at > tl)) prev_d = word;
    @(negedge clk);
    start = 1'b0; abort = 1'b0; din_valid = 1'b0;
  endtask

  initial begin
    logic [W-1:0] w;
    logic [NBITS-1:0] rb;
    logic         pb;
    int           tl, ab, xs;

    rst_n = 1'b0; start = 1'b0; din = 1'b0; din_valid = 1'b0; abort = 1'b0;
    prev_d = '0;
    #12;
    check_all("reset", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("reset_release latch_rst", 32'(latch_rst), 32'd1);
    @(posedge clk); #1;
    check_all("after_release", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    fill_valid(0, 0, 1'b0);
    run_frame("nominal", 8'hA5, 1'b0, 0, 0);

    fill_valid(4, 3, 1'b0);
    run_frame("stall", 8'hA5, 1'b0, 0, 0);

    fill_valid(0, 0, 1'b0);
    run_frame("start_busy", 8'h3C, 1'b0, 5, 0);
    check_all("start_busy idle", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    fill_valid(0, 0, 1'b0);
    run_frame("abort_strobe", 8'hC3, 1'b0, 0, NBITS + SL + 1);

    fill_valid(0, 0, 1'b0);
    run_frame("abort_shift", 8'h5A, 1'b0, 0, 4);

    // Simultaneous start and abort while idle must leave the loader idle.
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    check_all("start_abort_idle", prev_d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); start = 1'b0; abort = 1'b0;
    @(posedge clk); #1;
    check_all("start_abort_idle2", prev_d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef LATCH_FRAME_PARITY_EN
    fill_valid(0, 0, 1'b0);
    run_frame("par_good", 8'hA5, 1'b0, 0, 0);
    fill_valid(0, 0, 1'b0);
    run_frame("par_good2", 8'h5B, 1'b1, 0, 0);
    fill_valid(0, 0, 1'b0);
    run_frame("par_bad", 8'hA5, 1'b1, 0, 0);
`endif

    for (int f = 0; f < 12; f++) begin
      w  = W'($urandom);
      pb = (^w) ^ ($urandom_range(3, 0) == 0);
      fill_valid(0, 0, 1'b1);
      tl = find_last();
      ab = ($urandom_range(4, 0) == 0) ? int'($urandom_range(tl + SL + 2, 1)) : 0;
      xs = (ab == 0 && $urandom_range(1, 0) == 1) ? int'($urandom_range(tl + SL + 1, 1)) : 0;
      run_frame($sformatf("rand%0d", f), w, pb, xs, ab);
    end

    // Asynchronous reset in the middle of the strobe pulse.
    rb = {8'hA5, {(NBITS-W){1'b0}}};
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < NBITS; i++) begin
      @(negedge clk); start = 1'b0; din_valid = 1'b1; din = rb[NBITS-1-i];
      @(posedge clk);
    end
    @(negedge clk); din_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_mid pre latch_en", 32'(latch_en), 32'd1);
    #3; rst_n = 1'b0; #1;
    check_all("rst_mid", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); rst_n = 1'b1; #1;
    check("rst_mid release latch_rst", 32'(latch_rst), 32'd1);
    @(posedge clk); #1;
    check_all("rst_mid after", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    prev_d = '0;

    fill_valid(2, 2, 1'b0);
    run_frame("post_reset", 8'h81, 1'b0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
